// File: rtl/frame_transmitter_if.sv
// frame_transmitter_if: gate-set inputs and serializer-side beat outputs of frame_transmitter
interface frame_transmitter_if #(
   parameter int FLIT_WIDTH = 8,
   parameter int GATE_WIDTH = 4,
   parameter int GATE_FOLDS = 2
);
   logic                             i_start;
   logic                             i_stall;
   logic [FLIT_WIDTH-1:0]            i_dt [GATE_WIDTH];
   logic [GATE_WIDTH-1:0]            i_vl;
   logic [GATE_WIDTH-1:0]            i_cr;
   logic [FLIT_WIDTH*GATE_FOLDS-1:0] o_tx;
   logic                             o_busy;
   logic                             o_adone;
   logic                             o_done;
   modport master (
      output i_start, i_stall, i_dt, i_vl, i_cr,
      input  o_tx, o_busy, o_adone, o_done
   );
   modport slave (
      input  i_start, i_stall, i_dt, i_vl, i_cr,
      output o_tx, o_busy, o_adone, o_done
   );
endinterface

// File: rtl/frame_transmitter.sv
// frame_transmitter: folds header, valid data flits and (with TX_CHECKSUM_EN) an XOR checksum flit into registered beats
module frame_transmitter #(
   parameter int FLIT_WIDTH = 8,
   parameter int GATE_WIDTH = 4,
   parameter int GATE_FOLDS = 2
) (
   input  logic               i_clk,
   input  logic               i_rst,
   frame_transmitter_if.slave bus
);
   localparam int HEADER_SIZE  = 1 + 2 * GATE_WIDTH;
   localparam int HEADER_FLITS = (HEADER_SIZE + FLIT_WIDTH - 1) / FLIT_WIDTH;
`ifdef TX_CHECKSUM_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int MAX_BEATS = (HEADER_FLITS + GATE_WIDTH + P + GATE_FOLDS - 1) / GATE_FOLDS;
   localparam int SLOTS     = MAX_BEATS * GATE_FOLDS;
   localparam int CW        = MAX_BEATS > 1 ? $clog2(MAX_BEATS) : 1;
   localparam int PW        = $clog2(GATE_WIDTH + 1);
   localparam int SW        = SLOTS > 1 ? $clog2(SLOTS) : 1;
   localparam int HW        = HEADER_FLITS * FLIT_WIDTH;
   localparam int BW        = FLIT_WIDTH * GATE_FOLDS;

   typedef enum logic {IDLE, SEND} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [GATE_WIDTH-1:0] vl_q, vl_d, cr_q, cr_d;
   logic [FLIT_WIDTH-1:0] dt_q [GATE_WIDTH];
   logic [FLIT_WIDTH-1:0] dt_d [GATE_WIDTH];
   logic [BW-1:0]         tx_q, tx_d;
   logic                  adone_q, adone_d, done_q, done_d;

   logic                  accept, adv;
   logic [GATE_WIDTH-1:0] src_vl, src_cr;
   logic [FLIT_WIDTH-1:0] src_dt [GATE_WIDTH];
   logic [HW-1:0]         hdr;
   logic [PW-1:0]         pop;
   logic [PW-1:0]         pref [GATE_WIDTH];
   logic [FLIT_WIDTH-1:0] flits [SLOTS];
   logic [SW-1:0]         idx;
   logic [CW:0]           beats;
   logic [CW-1:0]         nb;
   logic [BW-1:0]         beat_tx;
`ifdef TX_CHECKSUM_EN
   logic [FLIT_WIDTH-1:0] csum;
`endif

   assign accept = bus.i_start && (state_q == IDLE || (done_q && !bus.i_stall));
   assign adv    = accept || (state_q == SEND && !bus.i_stall);

   // Build the dense frame of whichever gate set the next beat belongs to and pick that beat
   always_comb begin
      src_vl = accept ? bus.i_vl : vl_q;
      src_cr = accept ? bus.i_cr : cr_q;
      for (int g = 0; g < GATE_WIDTH; g++) src_dt[g] = accept ? bus.i_dt[g] : dt_q[g];
      hdr = HW'({1'b1, src_vl, src_cr}) << (HW - HEADER_SIZE);
      pop = '0;
      for (int g = 0; g < GATE_WIDTH; g++) begin
         pref[g] = pop;
         pop     = pop + PW'(src_vl[g]);
      end
      flits = '{default: '0};
      for (int k = 0; k < HEADER_FLITS; k++) flits[k] = hdr[HW-1-k*FLIT_WIDTH -: FLIT_WIDTH];
      for (int g = 0; g < GATE_WIDTH; g++) begin
         idx = SW'(HEADER_FLITS) + SW'(pref[g]);
         if (src_vl[g]) flits[idx] = src_dt[g];
      end
`ifdef TX_CHECKSUM_EN
      csum = '0;
      for (int k = 0; k < HEADER_FLITS; k++) csum = csum ^ hdr[HW-1-k*FLIT_WIDTH -: FLIT_WIDTH];
      for (int g = 0; g < GATE_WIDTH; g++) csum = csum ^ (src_vl[g] ? src_dt[g] : '0);
      idx = SW'(HEADER_FLITS) + SW'(pop);
      flits[idx] = csum;
`endif
      beats   = (CW+1)'((HEADER_FLITS + int'(pop) + P + GATE_FOLDS - 1) / GATE_FOLDS);
      nb      = accept ? '0 : cnt_q + CW'(1);
      beat_tx = '0;
      for (int s = 0; s < GATE_FOLDS; s++) begin
         idx = SW'(int'(nb) * GATE_FOLDS + s);
         beat_tx[BW-1-s*FLIT_WIDTH -: FLIT_WIDTH] = flits[idx];
      end
   end

   // Next state, snapshot capture and next registered beat/flags; everything holds while stalled
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      vl_d    = vl_q;
      cr_d    = cr_q;
      dt_d    = dt_q;
      tx_d    = tx_q;
      adone_d = adone_q;
      done_d  = done_q;
      if (accept) begin
         vl_d = bus.i_vl;
         cr_d = bus.i_cr;
         dt_d = bus.i_dt;
      end
      if (adv) begin
         state_d = (accept || !done_q) ? SEND : IDLE;
         cnt_d   = state_d == SEND ? nb : '0;
         tx_d    = state_d == SEND ? beat_tx : '0;
         done_d  = state_d == SEND && {1'b0, nb} == beats - (CW+1)'(1);
         adone_d = state_d == SEND && (beats == (CW+1)'(1) || {1'b0, nb} == beats - (CW+1)'(2));
      end
   end

   // State and output registers; reset aborts any frame in flight
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         vl_q    <= '0;
         cr_q    <= '0;
         dt_q    <= '{default: '0};
         tx_q    <= '0;
         adone_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         vl_q    <= vl_d;
         cr_q    <= cr_d;
         dt_q    <= dt_d;
         tx_q    <= tx_d;
         adone_q <= adone_d;
         done_q  <= done_d;
      end
   end

   assign bus.o_tx    = tx_q;
   assign bus.o_busy  = state_q == SEND;
   assign bus.o_adone = adone_q;
   assign bus.o_done  = done_q;
endmodule
